// File: rtl/uart_pkg.sv
// Shared UART constants, FSM state encoding and frame-length helper
// for the transmit scheduler.
package uart_pkg;

    localparam int unsigned N_TICKS     = 16;
    localparam int unsigned DEF_NB_DATA = 8;
    localparam int unsigned DEF_NB_STOP = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_LAUNCH = 3'b010,
        ST_WAIT   = 3'b100
    } state_t;

    // Start bit + data bits + stop bits at 16 ticks each, plus idle guard ticks.
    function automatic int unsigned frame_ticks(input int unsigned nb_data,
                                                input int unsigned nb_stop,
                                                input int unsigned n_guard);
        return N_TICKS * (1 + nb_data + nb_stop) + n_guard;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: priority starts just above pointer
// and ascends with wrap-around; grant is one-hot or zero.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    pointer,
    output logic [N_REQ-1:0] grant
);

    logic [N_REQ-1:0] hi_grant;
    logic [N_REQ-1:0] lo_grant;
    logic             hi_found;
    logic             lo_found;

    // Requests above the pointer win; otherwise the lowest one at or below it.
    always_comb begin
        hi_grant = '0;
        lo_grant = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req[i]) begin
                if (i > 32'(pointer)) begin
                    if (!hi_found) begin
                        hi_grant[i] = 1'b1;
                        hi_found    = 1'b1;
                    end
                end else if (!lo_found) begin
                    lo_grant[i] = 1'b1;
                    lo_found    = 1'b1;
                end
            end
        end
        grant = hi_found ? hi_grant : lo_grant;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between N_REQ byte requesters: round-robin pick,
// one start pulse per frame, then holds off for a full frame plus guard ticks.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned NB_DATA       = DEF_NB_DATA,
    parameter int unsigned NB_STOP       = DEF_NB_STOP,
    parameter int unsigned N_GUARD_TICKS = 2
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_tick,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*NB_DATA-1:0] i_data,
    output logic [N_REQ-1:0]         o_grant,
    output logic                     o_start,
    output logic [NB_DATA-1:0]       o_data,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int unsigned FRAME_TICKS = frame_ticks(NB_DATA, NB_STOP, N_GUARD_TICKS);
    localparam int unsigned CW          = $clog2(FRAME_TICKS);
    localparam int unsigned PW          = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CW-1:0] LAST_TICK = CW'(FRAME_TICKS - 1);

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      count;
    logic [N_REQ-1:0]   sel;
    logic [N_REQ-1:0]   arb_grant;
    logic [PW-1:0]      last_grant;
    logic [PW-1:0]      arb_idx;
    logic [NB_DATA-1:0] data_q;
    logic [NB_DATA-1:0] arb_byte;
    logic               frame_end;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .req     (i_req),
        .pointer (last_grant),
        .grant   (arb_grant)
    );

    always_comb begin
        arb_idx  = '0;
        arb_byte = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) begin
                arb_idx  = PW'(i);
                arb_byte = i_data[i*NB_DATA +: NB_DATA];
            end
        end
    end

    assign frame_end = (state == ST_WAIT) && i_tick && (count == LAST_TICK);

    always_ff @(posedge i_clock) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE:   state_next = (|i_req) ? ST_LAUNCH : ST_IDLE;
            ST_LAUNCH: state_next = ST_WAIT;
            ST_WAIT:   state_next = frame_end ? ST_IDLE : ST_WAIT;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Byte and winner are captured in IDLE so later input changes cannot disturb the frame.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count      <= '0;
            sel        <= '0;
            last_grant <= PW'(N_REQ - 1);
            data_q     <= '1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|i_req) begin
                        sel        <= arb_grant;
                        last_grant <= arb_idx;
                        data_q     <= arb_byte;
                    end
                end
                ST_LAUNCH: count <= '0;
                ST_WAIT:   if (i_tick) count <= count + CW'(1);
                default:   count <= '0;
            endcase
        end
    end

    always_comb begin
        o_start = (state == ST_LAUNCH);
        o_grant = o_start ? sel : '0;
        o_busy  = (state == ST_LAUNCH) || (state == ST_WAIT);
        o_done  = frame_end && !i_reset;
        o_data  = data_q;
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: random ticks and data against
// a round-robin / tick-counting reference model.
module tb_uart_tx_scheduler;

    localparam int unsigned NREQ = 4;
    localparam int unsigned NBD  = 8;
    localparam int          FT   = 162;

    logic                clk = 1'b0;
    logic                rst;
    logic                tick;
    logic [NREQ-1:0]     req;
    logic [NREQ*NBD-1:0] data;
    logic [NREQ-1:0]     grant;
    logic                start;
    logic [NBD-1:0]      odata;
    logic                busy;
    logic                done;

    int tests = 0;
    int fails = 0;
    int last_idx;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .N_REQ         (NREQ),
        .NB_DATA       (NBD),
        .NB_STOP       (1),
        .N_GUARD_TICKS (2)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .i_tick  (tick),
        .i_req   (req),
        .i_data  (data),
        .o_grant (grant),
        .o_start (start),
        .o_data  (odata),
        .o_busy  (busy),
        .o_done  (done)
    );

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last + k) % NREQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // Advance one clock; tick for the new cycle is applied, then outputs are sampled.
    task automatic cyc(input logic t);
        @(posedge clk);
        #1 tick = t;
        #1;
    endtask

    // Entered at an IDLE cycle with req/data already set; leaves at the following IDLE cycle.
    task automatic frame(input int mode, input logic [NREQ-1:0] req_after,
                         output logic [NREQ-1:0] obs_grant);
        int exp_idx, ticks, bad_busy, bad_pulse, bad_data, early_done;
        logic [NBD-1:0]  exp_byte;
        logic [NREQ-1:0] exp_g;
        logic            finished, done_seen;
        exp_idx = rr_pick(last_idx, req);
        obs_grant = 'x;
        if (exp_idx < 0) begin
            tests++; fails++;
            $display("FAIL frame_setup: got no active request, required at least one");
            return;
        end
        exp_byte = data[exp_idx*NBD +: NBD];
        exp_g = '0;
        exp_g[exp_idx] = 1'b1;

        cyc(1'($urandom_range(0, 1)));
        obs_grant = grant;
        tests++; if (start !== 1'b1) begin fails++; $display("FAIL launch_start: got %b required 1", start); end
        tests++; if (grant !== exp_g) begin fails++; $display("FAIL launch_grant: got %b required %b", grant, exp_g); end
        tests++; if (odata !== exp_byte) begin fails++; $display("FAIL launch_data: got %h required %h", odata, exp_byte); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL launch_busy: got %b required 1", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL launch_done: got %b required 0", done); end
        last_idx = exp_idx;
        req = req_after;

        ticks = 0; bad_busy = 0; bad_pulse = 0; bad_data = 0; early_done = 0;
        finished = 1'b0; done_seen = 1'b0;
        for (int n = 0; n < 4000 && !finished; n++) begin
            logic t;
            t = 1'($urandom_range(0, 1));
            cyc(t);
            if (busy !== 1'b1) bad_busy++;
            if (start !== 1'b0 || grant !== '0) bad_pulse++;
            if (odata !== exp_byte) bad_data++;
            if (t && ticks == FT - 1) begin
                finished  = 1'b1;
                done_seen = done;
            end else if (done !== 1'b0) begin
                early_done++;
            end
            if (t) ticks++;
            if (mode == 1) begin
                data = $urandom;
                req  = 4'($urandom_range(0, 15));
            end else if (mode == 2) begin
                data = '1;
            end
        end
        tests++; if (finished !== 1'b1) begin fails++; $display("FAIL frame_timeout: got %0d ticks, required %0d", ticks, FT); end
        tests++; if (done_seen !== 1'b1) begin fails++; $display("FAIL done_pulse: got %b required 1", done_seen); end
        tests++; if (early_done != 0) begin fails++; $display("FAIL early_done: got %0d cycles required 0", early_done); end
        tests++; if (bad_busy != 0) begin fails++; $display("FAIL wait_busy: got %0d low cycles required 0", bad_busy); end
        tests++; if (bad_pulse != 0) begin fails++; $display("FAIL wait_pulses: got %0d cycles required 0", bad_pulse); end
        tests++; if (bad_data != 0) begin fails++; $display("FAIL wait_data: got %0d changed cycles required 0", bad_data); end

        cyc(1'($urandom_range(0, 1)));
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b required 0", busy); end
        tests++; if (start !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL idle_pulses: got start=%b done=%b required 0 0", start, done); end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; data = $urandom; tick = 1'b0;
        cyc(1'b1);
        cyc(1'b0);
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL reset_grant: got %b required 0000", grant); end
        tests++; if (start !== 1'b0) begin fails++; $display("FAIL reset_start: got %b required 0", start); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b required 0", done); end
        tests++; if (odata !== 8'hFF) begin fails++; $display("FAIL reset_data: got %h required ff", odata); end
        last_idx = NREQ - 1;
        rst = 1'b0; req = '0;
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        for (int n = 0; n < 8; n++) begin
            cyc(1'($urandom_range(0, 1)));
            data = $urandom;
            if (busy !== 1'b0 || start !== 1'b0 || grant !== '0 || done !== 1'b0 || odata !== 8'hFF) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL idle_quiet: got %0d active cycles required 0", bad); end
    endtask

    task automatic test_all_four();
        logic [NREQ-1:0] g;
        int order [5] = '{0, 1, 2, 3, 0};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            logic [NREQ-1:0] e;
            data = $urandom;
            frame(0, 4'b1111, g);
            e = '0; e[order[i]] = 1'b1;
            tests++; if (g !== e) begin fails++; $display("FAIL rr_order_%0d: got %b required %b", i, g, e); end
        end
        req = '0;
    endtask

    task automatic test_single();
        logic [NREQ-1:0] g;
        data = $urandom; data[7:0] = 8'hA5; req = 4'b0001;
        frame(0, 4'b0000, g);
        tests++; if (g !== 4'b0001) begin fails++; $display("FAIL single_grant: got %b required 0001", g); end
    endtask

    task automatic test_pattern();
        logic [NREQ-1:0] g;
        data = $urandom; req = 4'b0010;
        frame(0, 4'b1010, g);
        tests++; if (g !== 4'b0010) begin fails++; $display("FAIL pattern_setup: got %b required 0010", g); end
        frame(0, 4'b1010, g);
        tests++; if (g !== 4'b1000) begin fails++; $display("FAIL pattern_first: got %b required 1000", g); end
        frame(0, 4'b0000, g);
        tests++; if (g !== 4'b0010) begin fails++; $display("FAIL pattern_second: got %b required 0010", g); end
    endtask

    task automatic test_data_hold();
        logic [NREQ-1:0] g;
        data = $urandom; data[23:16] = 8'h3C; req = 4'b0100;
        frame(2, 4'b0000, g);
        for (int i = 0; i < 4; i++) begin
            data = $urandom;
            req  = 4'($urandom_range(1, 15));
            frame(1, 4'b0000, g);
        end
    endtask

    task automatic test_drop();
        logic [NREQ-1:0] g;
        data = $urandom; req = 4'b0001;
        frame(0, 4'b0110, g);
        req = 4'b0100;
        frame(0, 4'b0000, g);
        tests++; if (g !== 4'b0100) begin fails++; $display("FAIL drop_skip: got %b required 0100", g); end
    endtask

    task automatic test_mid_reset();
        logic [NREQ-1:0] g;
        int ticks, bad_busy;
        logic hit;
        data = $urandom; req = 4'b0100;
        cyc(1'b1);
        tests++; if (start !== 1'b1 || grant !== 4'b0100) begin fails++; $display("FAIL mr_launch: got start=%b grant=%b required 1 0100", start, grant); end
        req = '0; ticks = 0; bad_busy = 0; hit = 1'b0;
        for (int n = 0; n < 2000 && !hit; n++) begin
            logic t;
            t = 1'($urandom_range(0, 1));
            cyc(t);
            if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
            if (t) ticks++;
            if (t && ticks == 80) begin
                hit = 1'b1; rst = 1'b1; req = 4'b1101;
            end
        end
        tests++; if (hit !== 1'b1 || bad_busy != 0) begin fails++; $display("FAIL mr_wait: got hit=%b bad=%0d required 1 0", hit, bad_busy); end
        cyc(1'b1);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mr_busy: got %b required 0", busy); end
        tests++; if (done !== 1'b0 || start !== 1'b0 || grant !== '0) begin fails++; $display("FAIL mr_pulses: got done=%b start=%b grant=%b required 0", done, start, grant); end
        tests++; if (odata !== 8'hFF) begin fails++; $display("FAIL mr_data: got %h required ff", odata); end
        rst = 1'b0; last_idx = NREQ - 1;
        frame(0, 4'b0000, g);
        tests++; if (g !== 4'b0001) begin fails++; $display("FAIL mr_regrant: got %b required 0001", g); end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; req = '0; data = '0; last_idx = NREQ - 1;
        test_reset();
        test_idle();
        test_all_four();
        test_single();
        test_pattern();
        test_data_hold();
        test_drop();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
